// File: rtl/refmem_ecc_rmw_if.sv
// rtl/refmem_ecc_rmw_if.sv - request/read-response bus of the ECC reference memory
// Master drives requests and consumes read results; slave is the memory model.

interface refmem_ecc_rmw_if #(
   parameter int LANES = 2,
   parameter int AW    = 9
);
   logic                  req;
   logic                  req_we;
   logic [AW-1:0]         req_addr;
   logic [32*LANES-1:0]   req_wrdata;
   logic [32*LANES-1:0]   req_bitmask;
   logic                  req_ready;
   logic                  rd_valid;
   logic [32*LANES-1:0]   rd_data;
   logic [LANES-1:0]      ecc_single_error;
   logic [LANES-1:0]      ecc_double_error;

   modport master (
      output req, req_we, req_addr, req_wrdata, req_bitmask,
      input  req_ready, rd_valid, rd_data, ecc_single_error, ecc_double_error
   );

   modport slave (
      input  req, req_we, req_addr, req_wrdata, req_bitmask,
      output req_ready, rd_valid, rd_data, ecc_single_error, ecc_double_error
   );
endinterface

// File: rtl/refmem_ecc_rmw.sv
// rtl/refmem_ecc_rmw.sv - golden reference memory with per-lane SECDED, RMW and scrub
// Code word per lane: [31:0] data, [37:32] Hamming checks, [38] overall parity.

module ecc_encode (
   input  logic [31:0] data,
   output logic [38:0] code
);
   // Hamming position of data bit idx: the idx-th non-power-of-two in 1..38
   function automatic logic [5:0] data_pos(input int idx);
      int n;
      logic [5:0] p;
      n = 0;
      p = '0;
      for (int q = 1; q < 39; q++) begin
         if ((q & (q - 1)) != 0) begin
            if (n == idx) p = q[5:0];
            n++;
         end
      end
      return p;
   endfunction

   logic [5:0] chk;
   logic [5:0] pos;

   always_comb begin
      chk = '0;
      pos = '0;
      for (int i = 0; i < 32; i++) begin
         pos = data_pos(i);
         for (int j = 0; j < 6; j++) begin
            if (pos[j]) chk[j] = chk[j] ^ data[i];
         end
      end
      code = {^{chk, data}, chk, data};
   end
endmodule

module ecc_decode (
   input  logic [38:0] code,
   output logic [31:0] data,
   output logic        single_err,
   output logic        double_err
);
   function automatic logic [5:0] data_pos(input int idx);
      int n;
      logic [5:0] p;
      n = 0;
      p = '0;
      for (int q = 1; q < 39; q++) begin
         if ((q & (q - 1)) != 0) begin
            if (n == idx) p = q[5:0];
            n++;
         end
      end
      return p;
   endfunction

   logic [5:0] syn;
   logic [5:0] pos;
   logic       overall;

   always_comb begin
      syn = code[37:32];
      pos = '0;
      for (int i = 0; i < 32; i++) begin
         pos = data_pos(i);
         for (int j = 0; j < 6; j++) begin
            if (pos[j]) syn[j] = syn[j] ^ code[i];
         end
      end
      overall    = ^code;
      data       = code[31:0];
      single_err = 1'b0;
      double_err = 1'b0;
      // odd overall parity means one flip; syndrome names the position (0 = parity bit)
      if (overall) begin
         single_err = 1'b1;
         for (int i = 0; i < 32; i++) begin
            if (data_pos(i) == syn) data[i] = ~code[i];
         end
      end else if (syn != 6'd0) begin
         double_err = 1'b1;
      end
   end
endmodule

module refmem_ecc_rmw #(
   parameter int LANES = 2,
   parameter int DEPTH = 512,
   parameter int AW    = 9
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                cfg_ecc_enable_i,
   input  logic                cfg_outreg_i,
   input  logic                cfg_scrub_i,
   input  logic [39*LANES-1:0] err_inject_i,
   input  logic                cnt_clear_i,
   output logic [15:0]         sec_count_o,
   output logic [15:0]         ded_count_o,
   refmem_ecc_rmw_if.slave     bus
);
   localparam int DW = 32 * LANES;
   localparam int CW = 39 * LANES;

   typedef enum logic [1:0] {ST_IDLE, ST_RMW, ST_SCRUB} state_t;

   state_t           state;
   logic             ready_q;
   logic [CW-1:0]    mem [DEPTH];

   logic [AW-1:0]    hold_addr;
   logic [DW-1:0]    hold_data;
   logic [DW-1:0]    hold_mask;

   logic [AW-1:0]    rd_addr;
   logic             req_in_range;
   logic             rd_in_range;
   logic [CW-1:0]    old_code;
   logic [DW-1:0]    dec_data;
   logic [LANES-1:0] dec_single;
   logic [LANES-1:0] dec_double;
   logic [DW-1:0]    enc_in;
   logic [CW-1:0]    enc_code;
   logic [DW-1:0]    wr_data;
   logic [DW-1:0]    wr_mask;
   logic [DW-1:0]    old_data;
   logic [DW-1:0]    merged;
   logic [LANES-1:0] lane_full;
   logic [CW-1:0]    new_code;

   logic             accept;
   logic             rd_acc;
   logic             wr_partial;
   logic             scrub_needed;
   logic             mem_we;
   logic             cnt_access;
   logic             sec_hit;
   logic             ded_hit;

   logic             s1_valid, s2_valid;
   logic [DW-1:0]    s1_data, s2_data;
   logic [LANES-1:0] s1_sec, s2_sec, s1_ded, s2_ded;
   logic [15:0]      sec_cnt_q, ded_cnt_q;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      ecc_decode u_dec (
         .code       (old_code[39*l +: 39]),
         .data       (dec_data[32*l +: 32]),
         .single_err (dec_single[l]),
         .double_err (dec_double[l])
      );
      ecc_encode u_enc (
         .data (enc_in[32*l +: 32]),
         .code (enc_code[39*l +: 39])
      );
   end

   // In RMW/SCRUB the held address is re-read; SCRUB holds an all-zero mask so merge = corrected old
   always_comb begin
      rd_addr      = (state == ST_IDLE) ? bus.req_addr : hold_addr;
      req_in_range = int'(bus.req_addr) < DEPTH;
      rd_in_range  = int'(rd_addr) < DEPTH;
      old_code     = rd_in_range ? mem[rd_addr] : '0;
      wr_data      = (state == ST_IDLE) ? bus.req_wrdata  : hold_data;
      wr_mask      = (state == ST_IDLE) ? bus.req_bitmask : hold_mask;
      old_data     = '0;
      merged       = '0;
      lane_full    = '0;
      new_code     = '0;
      for (int l = 0; l < LANES; l++) begin
         old_data[32*l +: 32] = cfg_ecc_enable_i ? dec_data[32*l +: 32] : old_code[39*l +: 32];
         lane_full[l]         = &wr_mask[32*l +: 32];
         merged[32*l +: 32]   = (wr_data[32*l +: 32] & wr_mask[32*l +: 32]) |
                                (old_data[32*l +: 32] & ~wr_mask[32*l +: 32]);
      end
      enc_in = (state == ST_IDLE) ? wr_data : merged;
      for (int l = 0; l < LANES; l++) begin
         if (!cfg_ecc_enable_i)
            new_code[39*l +: 39] = {7'd0, merged[32*l +: 32]} ^ err_inject_i[39*l +: 39];
         else if (state == ST_IDLE)
            new_code[39*l +: 39] = enc_code[39*l +: 39] ^ err_inject_i[39*l +: 39];
         else if (dec_double[l] && !lane_full[l])
            new_code[39*l +: 39] = old_code[39*l +: 39];
         else
            new_code[39*l +: 39] = enc_code[39*l +: 39];
      end
   end

   always_comb begin
      accept       = bus.req && ready_q && (state == ST_IDLE);
      rd_acc       = accept && !bus.req_we;
      wr_partial   = cfg_ecc_enable_i && !(&lane_full);
      sec_hit      = cfg_ecc_enable_i && (|dec_single);
      ded_hit      = cfg_ecc_enable_i && (|dec_double);
      scrub_needed = cfg_scrub_i && sec_hit && !ded_hit;
      cnt_access   = (rd_acc && req_in_range) || (state == ST_RMW);
      mem_we       = rst_n_i && ((state == ST_RMW) || (state == ST_SCRUB) ||
                     (accept && bus.req_we && req_in_range && !wr_partial));
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) mem[rd_addr] <= new_code;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= ST_IDLE;
         ready_q   <= 1'b1;
         hold_addr <= '0;
         hold_data <= '0;
         hold_mask <= '0;
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         s1_sec    <= '0;
         s1_ded    <= '0;
         s2_valid  <= 1'b0;
         s2_data   <= '0;
         s2_sec    <= '0;
         s2_ded    <= '0;
         sec_cnt_q <= '0;
         ded_cnt_q <= '0;
      end else begin
         s1_valid <= rd_acc;
         if (rd_acc) begin
            s1_data <= req_in_range ? old_data : '0;
            s1_sec  <= (req_in_range && cfg_ecc_enable_i) ? dec_single : '0;
            s1_ded  <= (req_in_range && cfg_ecc_enable_i) ? dec_double : '0;
         end
         s2_valid <= s1_valid;
         s2_data  <= s1_data;
         s2_sec   <= s1_sec;
         s2_ded   <= s1_ded;

         if (cnt_clear_i)
            sec_cnt_q <= '0;
         else if (cnt_access && sec_hit && sec_cnt_q != 16'hFFFF)
            sec_cnt_q <= sec_cnt_q + 16'd1;
         if (cnt_clear_i)
            ded_cnt_q <= '0;
         else if (cnt_access && ded_hit && ded_cnt_q != 16'hFFFF)
            ded_cnt_q <= ded_cnt_q + 16'd1;

         case (state)
            ST_IDLE: begin
               if (accept && bus.req_we && req_in_range && wr_partial) begin
                  state     <= ST_RMW;
                  ready_q   <= 1'b0;
                  hold_addr <= bus.req_addr;
                  hold_data <= bus.req_wrdata;
                  hold_mask <= bus.req_bitmask;
               end else if (rd_acc && req_in_range && scrub_needed) begin
                  state     <= ST_SCRUB;
                  ready_q   <= 1'b0;
                  hold_addr <= bus.req_addr;
                  hold_mask <= '0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      bus.req_ready        = ready_q;
      bus.rd_valid         = cfg_outreg_i ? s2_valid : s1_valid;
      bus.rd_data          = cfg_outreg_i ? s2_data  : s1_data;
      bus.ecc_single_error = cfg_outreg_i ? s2_sec   : s1_sec;
      bus.ecc_double_error = cfg_outreg_i ? s2_ded   : s1_ded;
      sec_count_o          = sec_cnt_q;
      ded_count_o          = ded_cnt_q;
   end
endmodule

// File: tb/tb_refmem_ecc_rmw.sv
// tb/tb_refmem_ecc_rmw.sv - directed plus randomized bench for refmem_ecc_rmw
// Reference keeps per-lane data and an injected-flip count (0 clean, 1 single, 2 double).

module tb_refmem_ecc_rmw;
   localparam int LANES = 2;
   localparam int DEPTH = 500;
   localparam int AW    = 9;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_ecc = 1'b1;
   logic        cfg_outreg = 1'b0;
   logic        cfg_scrub = 1'b0;
   logic [77:0] err_inject = '0;
   logic        cnt_clear = 1'b0;
   logic [15:0] sec_count, ded_count;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_data [64][2];
   int          m_err  [64][2];
   int          m_sec = 0;
   int          m_ded = 0;

   refmem_ecc_rmw_if #(.LANES(LANES), .AW(AW)) bus ();

   refmem_ecc_rmw #(.LANES(LANES), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .cfg_ecc_enable_i (cfg_ecc),
      .cfg_outreg_i     (cfg_outreg),
      .cfg_scrub_i      (cfg_scrub),
      .err_inject_i     (err_inject),
      .cnt_clear_i      (cnt_clear),
      .sec_count_o      (sec_count),
      .ded_count_o      (ded_count),
      .bus              (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (n == 8) check({tag, "_ready_timeout"}, 64'(bus.req_ready), 64'd1);
   endtask

   task automatic do_write(input int a, input logic [63:0] d, input logic [63:0] m,
                           input logic [77:0] inj);
      bit in_rng, partial, any_s, any_d, full;
      in_rng  = a < DEPTH;
      partial = cfg_ecc && ((m[31:0] != '1) || (m[63:32] != '1));
      wait_ready("wr");
      bus.req = 1'b1; bus.req_we = 1'b1; bus.req_addr = a[AW-1:0];
      bus.req_wrdata = d; bus.req_bitmask = m; err_inject = inj;
      @(posedge clk);
      #1;
      bus.req = 1'b0; err_inject = '0;
      @(negedge clk);
      if (partial && in_rng) begin
         check("rmw_ready_low", 64'(bus.req_ready), 64'd0);
         @(negedge clk);
         check("rmw_ready_back", 64'(bus.req_ready), 64'd1);
      end else begin
         check("wr_ready", 64'(bus.req_ready), 64'd1);
      end
      if (in_rng) begin
         any_s = 0; any_d = 0;
         for (int l = 0; l < 2; l++) begin
            full = (m[32*l +: 32] == '1);
            if (!cfg_ecc) begin
               m_data[a][l] = ((d[32*l +: 32] & m[32*l +: 32]) | (m_data[a][l] & ~m[32*l +: 32]))
                              ^ inj[39*l +: 32];
               m_err[a][l] = 0;
            end else if (!partial) begin
               m_data[a][l] = d[32*l +: 32];
               m_err[a][l]  = $countones(inj[39*l +: 39]);
            end else begin
               if (m_err[a][l] == 1) any_s = 1;
               if (m_err[a][l] == 2) any_d = 1;
               if (!(m_err[a][l] == 2 && !full)) begin
                  m_data[a][l] = (d[32*l +: 32] & m[32*l +: 32]) | (m_data[a][l] & ~m[32*l +: 32]);
                  m_err[a][l]  = 0;
               end
            end
         end
         if (any_s) m_sec = sat(m_sec);
         if (any_d) m_ded = sat(m_ded);
      end
      check("wr_sec_count", 64'(sec_count), 64'(m_sec));
      check("wr_ded_count", 64'(ded_count), 64'(m_ded));
   endtask

   task automatic do_read(input int a, input bit clr);
      logic [63:0] exp_d, keep;
      logic [1:0]  es, ed;
      bit          in_rng, scrub;
      exp_d = '0; keep = '1; es = '0; ed = '0;
      in_rng = a < DEPTH;
      if (in_rng) begin
         for (int l = 0; l < 2; l++) begin
            exp_d[32*l +: 32] = m_data[a][l];
            if (cfg_ecc) begin
               es[l] = (m_err[a][l] == 1);
               ed[l] = (m_err[a][l] == 2);
               if (ed[l]) keep[32*l +: 32] = '0;
            end
         end
      end
      scrub = in_rng && cfg_ecc && cfg_scrub && (es != 0) && (ed == 0);
      wait_ready("rd");
      bus.req = 1'b1; bus.req_we = 1'b0; bus.req_addr = a[AW-1:0]; cnt_clear = clr;
      @(posedge clk);
      #1;
      bus.req = 1'b0; cnt_clear = 1'b0;
      @(negedge clk);
      check("rd_ready_n1", 64'(bus.req_ready), 64'(!scrub));
      if (cfg_outreg) begin
         check("rd_valid_early", 64'(bus.rd_valid), 64'd0);
         @(negedge clk);
      end
      if (clr) begin
         m_sec = 0; m_ded = 0;
      end else if (in_rng && cfg_ecc) begin
         if (es != 0) m_sec = sat(m_sec);
         if (ed != 0) m_ded = sat(m_ded);
      end
      check("rd_valid", 64'(bus.rd_valid), 64'd1);
      check("rd_data", bus.rd_data & keep, exp_d & keep);
      check("rd_single", 64'(bus.ecc_single_error), 64'(es));
      check("rd_double", 64'(bus.ecc_double_error), 64'(ed));
      check("rd_sec_count", 64'(sec_count), 64'(m_sec));
      check("rd_ded_count", 64'(ded_count), 64'(m_ded));
      if (scrub)
         for (int l = 0; l < 2; l++) if (m_err[a][l] == 1) m_err[a][l] = 0;
      @(negedge clk);
      check("rd_valid_pulse", 64'(bus.rd_valid), 64'd0);
   endtask

   function automatic logic [77:0] rand_inj();
      logic [77:0] v;
      v = '0;
      for (int l = 0; l < 2; l++) begin
         int r, b0, b1;
         r  = $urandom_range(0, 5);
         b0 = $urandom_range(0, 38);
         b1 = (b0 + $urandom_range(1, 38)) % 39;
         if (r == 4) v[39*l + b0] = 1'b1;
         else if (r == 5) begin
            v[39*l + b0] = 1'b1;
            v[39*l + b1] = 1'b1;
         end
      end
      return v;
   endfunction

   initial begin
      logic [63:0] d, m;
      logic [77:0] inj;
      int a;
      bus.req = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
      bus.req_wrdata = '0; bus.req_bitmask = '0;
      for (int i = 0; i < 64; i++) begin
         m_data[i][0] = '0; m_data[i][1] = '0; m_err[i][0] = 0; m_err[i][1] = 0;
      end
      repeat (3) @(negedge clk);
      check("reset_ready", 64'(bus.req_ready), 64'd1);
      check("reset_valid", 64'(bus.rd_valid), 64'd0);
      check("reset_data", bus.rd_data, 64'd0);
      check("reset_flags", 64'({bus.ecc_single_error, bus.ecc_double_error}), 64'd0);
      check("reset_counts", 64'({sec_count, ded_count}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_write(5, 64'h0123_4567_89AB_CDEF, '1, '0);
      do_read(5, 0);
      cfg_outreg = 1'b1;
      do_read(5, 0);
      cfg_outreg = 1'b0;

      cfg_scrub = 1'b1;
      inj = '0; inj[0] = 1'b1;
      do_write(3, '1, '1, inj);
      do_read(3, 0);
      do_read(3, 0);

      do_write(7, '0, '1, '0);
      do_write(7, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0000_00FF_0000_0000, '0);
      do_read(7, 0);
      check("rmw_merge_value", 64'(m_data[7][1]), 64'h0000_00AA);

      inj = '0; inj[0] = 1'b1; inj[1] = 1'b1;
      do_write(9, 64'h1111_2222_3333_4444, '1, inj);
      do_write(9, 64'hFFFF_FFFF_FFFF_FFFF, 64'h00FF_00FF_00FF_00FF, '0);
      check("ded_after_rmw", 64'(ded_count), 64'd1);
      do_read(9, 0);

      cfg_scrub = 1'b0;
      inj = '0; inj[39 + 17] = 1'b1;
      do_write(11, 64'hCAFE_F00D_DEAD_BEEF, '1, inj);
      @(negedge clk);
      force dut.sec_cnt_q = 16'hFFFE;
      #1;
      release dut.sec_cnt_q;
      m_sec = 65534;
      @(negedge clk);
      check("sec_preload", 64'(sec_count), 64'hFFFE);
      repeat (3) do_read(11, 0);
      check("sec_saturated", 64'(sec_count), 64'hFFFF);
      do_read(11, 1);
      check("clear_wins", 64'(sec_count), 64'd0);

      for (int i = 16; i < 32; i++) do_write(i, {$urandom, $urandom}, '1, '0);
      for (int k = 0; k < 200; k++) begin
         cfg_scrub  = 1'($urandom_range(0, 1));
         cfg_outreg = 1'($urandom_range(0, 1));
         a = $urandom_range(16, 31);
         if ($urandom_range(0, 1) == 1) begin
            d = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) begin
               do_write(a, d, '1, rand_inj());
            end else begin
               m = {$urandom, $urandom};
               if ($urandom_range(0, 1) == 1) m[31:0] = '1;
               else if ($urandom_range(0, 1) == 1) m[63:32] = '1;
               do_write(a, d, m, '0);
            end
         end else begin
            do_read(a, 0);
         end
      end
      cfg_outreg = 1'b0;
      cfg_scrub  = 1'b1;

      do_write(505, 64'h5555_5555_5555_5555, 64'h0000_FFFF_0000_FFFF, '0);
      do_read(505, 0);

      wait_ready("rst");
      bus.req = 1'b1; bus.req_we = 1'b1; bus.req_addr = 9'd7;
      bus.req_wrdata = '1; bus.req_bitmask = 64'h0000_0000_FFFF_0000;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      @(negedge clk);
      check("mid_rmw_ready", 64'(bus.req_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      check("async_reset_ready", 64'(bus.req_ready), 64'd1);
      check("async_reset_counts", 64'({sec_count, ded_count}), 64'd0);
      m_sec = 0; m_ded = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_read(7, 0);

      cfg_ecc = 1'b0;
      do_write(40, 64'h1357_9BDF_2468_ACE0, '1, '0);
      do_write(40, 64'hFFFF_0000_FFFF_0000, 64'hFF00_FF00_00FF_00FF, '0);
      do_read(40, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/refmem_ecc_rmw.md
# refmem_ecc_rmw

Parametrised single-clock reference memory for FPGA RAM verification. The word is LANES independent 32-bit lanes, each stored as a 39-bit SECDED code word. Partial-mask writes with ECC enabled run as true read-modify-write, and single-bit errors can optionally be scrubbed back to the array. The block also provides saturating error counters and error injection. It sits in the testbench beside the RAM under test as the golden model for the scoreboard.

## Interface
- LANES, 2: number of 32-bit data lanes per word.
- DEPTH, 512: number of words.
- AW, 9: address width; DEPTH ≤ 2^AW.
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- cfg_ecc_enable_i  in  1  1 = SECDED per lane. Static while requests are in flight.
- cfg_outreg_i  in  1  1 = extra output register stage.
- cfg_scrub_i  in  1  1 = write corrected code back after a single-error read.
- req_i  in  1  request valid.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  AW  word address.
- req_wrdata_i  in  32*LANES  write data.
- req_bitmask_i  in  32*LANES  per-bit write enable.
- err_inject_i  in  39*LANES  XOR mask applied to the code word written on a write request. Not applied on RMW merge or scrub write-back.
- req_ready_o  out  1  request accepted when req_i && req_ready_o.
- rd_valid_o  out  1  one-cycle pulse; rd_data_o and the error flags are valid.
- rd_data_o  out  32*LANES  read data, corrected when ECC is on.
- ecc_single_error_o  out  LANES  per-lane corrected single error, qualified by rd_valid_o.
- ecc_double_error_o  out  LANES  per-lane uncorrectable error, qualified by rd_valid_o.
- sec_count_o  out  16  accesses with ≥1 single error in any lane; saturating.
- ded_count_o  out  16  accesses with ≥1 double error in any lane; saturating.
- cnt_clear_i  in  1  synchronous clear of both counters.

## Operation
- Storage: DEPTH × 39*LANES bits. The array is not reset.
- Encode and decode reuse the codebase's ecc_encode and ecc_decode, one instance pair per lane.
- ECC off:
  - Each lane stores data in code bits [31:0]; check bits are written 0.
  - Writes apply the bitmask directly. Reads return bits [31:0] raw. Flags stay 0.
- ECC on, write, every lane mask all-ones: the encoded word (XOR err_inject_i) is written in one cycle.
- ECC on, write, any lane mask not all-ones: read-modify-write.
  - The old word is read and each lane decoded.
  - Merge per bit: new data where the mask is set, corrected old data elsewhere.
  - Full-mask lanes take new data unconditionally.
  - The merged word is re-encoded and written.
  - A partial-mask lane with a double error is left unmodified; the other lanes are written.
  - Counters update from the decoded old word. rd_valid_o is not asserted.
- Read: each lane is decoded. If cfg_scrub_i && ECC on && any single error && no double error in any lane, the corrected, re-encoded word is written back to the same address.
- FSM states:
  - IDLE: ready=1. Accepting a partial ECC write → RMW. Accepting a read that needs scrub → SCRUB. Otherwise stay in IDLE.
  - RMW: ready=0. Merge and write at the end of the cycle → IDLE.
  - SCRUB: ready=0. Write back → IDLE.
- Counters:
  - Increment by 1 per access (read or RMW), not per lane.
  - Hold at 16'hFFFF.
  - cnt_clear_i wins over a simultaneous increment.

## Timing
- Reset values: req_ready_o=1, rd_valid_o=0, rd_data_o=0, flags=0, counters=0, FSM=IDLE.
- Read accepted at edge N:
  - cfg_outreg_i=0: rd_valid_o, rd_data_o and flags valid in cycle N+1.
  - cfg_outreg_i=1: valid in cycle N+2.
  - Back-to-back reads give one result per cycle, unless a scrub inserts a one-cycle ready=0 bubble in N+1.
- Full write: the array is updated at edge N; a read of the same address accepted at N+1 sees the new data.
- RMW write accepted at N: ready=0 in cycle N+1, the array is written at edge N+1, and ready=1 again in cycle N+2.
- Scrub: the write-back happens at edge N+1. The read result in N+1 still shows the single-error flag.
- Counters update one cycle after the decode cycle.
- Reset asserted mid-RMW or mid-SCRUB: the pending write is dropped, the array is unchanged, and outputs return to reset values immediately (asynchronous).
- Addresses ≥ DEPTH: writes are ignored; reads return 0 with no flags.

## Test plan
- ECC on, LANES=2. Write addr 5 with data 64'h0123_4567_89AB_CDEF and mask all-ones, then read addr 5 → rd_valid_o in cycle N+1, data 64'h0123_4567_89AB_CDEF, flags 0, ready never drops.
- Repeat with cfg_outreg_i=1 → rd_valid_o at N+2, same data.
- Write addr 3 with data 64'hFFFF_FFFF_FFFF_FFFF and err_inject_i bit 0 set, scrub on. Read addr 3 → data correct, ecc_single_error_o=2'b01, sec_count_o=1, ready=0 for one cycle. Re-read addr 3 → single-error flags 0, sec_count_o stays 1.
- Write addr 7 with all-zero data, then write addr 7 with data 64'hAAAA_AAAA_AAAA_AAAA, mask 64'h0000_00FF_0000_0000 → ready low for exactly one cycle. Read addr 7 → 64'h0000_00AA_0000_0000, flags 0.
- Write addr 9 with err_inject_i bits 0 and 1 set in lane 0 (double error), then a partial-mask write to both lanes of addr 9 → lane 0 unchanged, lane 1 merged, ded_count_o=1.
- Force sec_count_o to 16'hFFFE, then issue three single-error reads → sec_count_o holds at 16'hFFFF. Assert cnt_clear_i in the same cycle as an increment → counter reads 0.
